mem_arbiter: RTL and testbench

Arbitrates the single unified memory port of the LC3B pipelined core between the fetch stage (instruction reads) and the MEM stage (data loads/stores). It runs each access for a fixed multi-cycle latency, returns read data with a one-cycle ready pulse, and generates `imem_r` for fetch and `mem_stall` for the pipeline. It sits between `FetchStage`/MEM stage and the memory array, replacing the externally driven `imem_r`/`mem_stall` used so far.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for the LC3B unified memory port: fetch vs MEM stage, fixed-latency accesses.
// Optional performance counters are enabled with `define LC3BP_MEM_ARB_PERF_EN.
module mem_arbiter #(
    parameter int MEM_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef LC3BP_MEM_ARB_PERF_EN
    output logic [15:0] perf_igrant,
    output logic [15:0] perf_dgrant,
    output logic [15:0] perf_conflict,
`endif
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_word,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        imem_r,
    output logic [15:0] instr,
    output logic        dmem_r,
    output logic [15:0] mem_rdata,
    output logic        mem_stall,
    output logic        ram_en,
    output logic [1:0]  ram_we,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        word_q, word_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        imem_r_q, imem_r_d;
    logic        dmem_r_q, dmem_r_d;
    logic        grant_i, grant_d;
    logic [15:0] load_data;

    always_comb begin
        if (word_q) begin
            load_data = ram_rdata;
        end else begin
            load_data = {8'h00, addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0]};
        end
    end

    // The ready pulse of a requester doubles as its grant mask for that cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        instr_d  = instr_q;
        rdata_d  = rdata_q;
        imem_r_d = 1'b0;
        dmem_r_d = 1'b0;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req && !dmem_r_q) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                    cnt_d   = LAT_M1;
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    word_d  = mem_word;
                    wdata_d = mem_wdata;
                end else if (if_req && !imem_r_q) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                    cnt_d   = LAT_M1;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    word_d  = 1'b1;
                    wdata_d = 16'h0000;
                end
            end
            BUSY_I: begin
                if (cnt_q == 4'd0) begin
                    instr_d  = ram_rdata;
                    imem_r_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BUSY_D: begin
                if (cnt_q == 4'd0) begin
                    rdata_d  = load_data;
                    dmem_r_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            we_q     <= 1'b0;
            word_q   <= 1'b0;
            wdata_q  <= 16'h0000;
            instr_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            imem_r_q <= 1'b0;
            dmem_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            instr_q  <= instr_d;
            rdata_q  <= rdata_d;
            imem_r_q <= imem_r_d;
            dmem_r_q <= dmem_r_d;
        end
    end

    always_comb begin
        ram_we = 2'b00;
        if (state_q == BUSY_D && we_q) begin
            if (word_q) begin
                ram_we = 2'b11;
            end else begin
                ram_we = addr_q[0] ? 2'b10 : 2'b01;
            end
        end
    end

    assign ram_en    = (state_q != IDLE);
    assign ram_addr  = addr_q[15:1];
    assign ram_wdata = word_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]};
    assign imem_r    = imem_r_q;
    assign dmem_r    = dmem_r_q;
    assign instr     = instr_q;
    assign mem_rdata = rdata_q;
    assign mem_stall = mem_req & ~dmem_r_q;

`ifdef LC3BP_MEM_ARB_PERF_EN
    logic [15:0] perf_igrant_q, perf_igrant_d;
    logic [15:0] perf_dgrant_q, perf_dgrant_d;
    logic [15:0] perf_conflict_q, perf_conflict_d;
    logic        conflict;

    assign conflict = (state_q == BUSY_D && if_req) || (state_q == BUSY_I && mem_req);

    always_comb begin
        perf_igrant_d   = perf_igrant_q;
        perf_dgrant_d   = perf_dgrant_q;
        perf_conflict_d = perf_conflict_q;
        if (grant_i && perf_igrant_q != 16'hFFFF) begin
            perf_igrant_d = perf_igrant_q + 16'd1;
        end
        if (grant_d && perf_dgrant_q != 16'hFFFF) begin
            perf_dgrant_d = perf_dgrant_q + 16'd1;
        end
        if (conflict && perf_conflict_q != 16'hFFFF) begin
            perf_conflict_d = perf_conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_igrant_q   <= 16'h0000;
            perf_dgrant_q   <= 16'h0000;
            perf_conflict_q <= 16'h0000;
        end else begin
            perf_igrant_q   <= perf_igrant_d;
            perf_dgrant_q   <= perf_dgrant_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_igrant   = perf_igrant_q;
    assign perf_dgrant   = perf_dgrant_q;
    assign perf_conflict = perf_conflict_q;
`else
    logic unused_grants;
    assign unused_grants = grant_i ^ grant_d;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=5) with a behavioural word-addressed RAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic        mem_word;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        imem_r;
    logic [15:0] instr;
    logic        dmem_r;
    logic [15:0] mem_rdata;
    logic        mem_stall;
    logic        ram_en;
    logic [1:0]  ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
`ifdef LC3BP_MEM_ARB_PERF_EN
    logic [15:0] perf_igrant;
    logic [15:0] perf_dgrant;
    logic [15:0] perf_conflict;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(5)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef LC3BP_MEM_ARB_PERF_EN
        .perf_igrant   (perf_igrant),
        .perf_dgrant   (perf_dgrant),
        .perf_conflict (perf_conflict),
`endif
        .if_req    (if_req),
        .if_addr   (if_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_word  (mem_word),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .imem_r    (imem_r),
        .instr     (instr),
        .dmem_r    (dmem_r),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    logic [15:0] mem [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
            if (ram_we[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
        end
    end
    assign ram_rdata = mem[ram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Issues one data access in IDLE and returns in the dmem_r cycle with mem_req dropped.
    task automatic run_d(input logic we, input logic word, input logic [15:0] a, input logic [15:0] wd);
        int n;
        mem_req = 1'b1; mem_we = we; mem_word = word; mem_addr = a; mem_wdata = wd;
        n = 0;
        do begin
            step();
            n++;
        end while (!dmem_r && n < 20);
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL d_latency addr=%h got %0d cycles required 6", a, n);
        end
        mem_req = 1'b0; mem_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, imem_r, dmem_r, instr, mem_rdata, mem_stall} !== '0) begin
            errors++;
            $display("FAIL reset_state en=%b we=%b addr=%h wd=%h ir=%b dr=%b instr=%h rd=%h stall=%b required all zero",
                     ram_en, ram_we, ram_addr, ram_wdata, imem_r, dmem_r, instr, mem_rdata, mem_stall);
        end
`ifdef LC3BP_MEM_ARB_PERF_EN
        checks++;
        if ({perf_igrant, perf_dgrant, perf_conflict} !== '0) begin
            errors++;
            $display("FAIL reset_perf got %h %h %h required 0 0 0", perf_igrant, perf_dgrant, perf_conflict);
        end
`endif
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 16'h3000;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) if_req = 1'b0;
            checks++;
            if (!(ram_en === 1'b1 && ram_addr === 15'h1800 && ram_we === 2'b00 && imem_r === 1'b0)) begin
                errors++;
                $display("FAIL fetch_busy cyc=%0d en=%b addr=%h we=%b ir=%b required 1 1800 00 0", i, ram_en, ram_addr, ram_we, imem_r);
            end
        end
        step();
        checks++;
        if (!(imem_r === 1'b1 && instr === 16'h1234 && ram_en === 1'b0)) begin
            errors++;
            $display("FAIL fetch_ready ir=%b instr=%h en=%b required 1 1234 0", imem_r, instr, ram_en);
        end
        step();
        checks++;
        if (!(imem_r === 1'b0 && instr === 16'h1234 && ram_en === 1'b0)) begin
            errors++;
            $display("FAIL fetch_hold ir=%b instr=%h en=%b required 0 1234 0", imem_r, instr, ram_en);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        if_req = 1'b1; if_addr = 16'h3000;
        mem_req = 1'b1; mem_we = 1'b0; mem_word = 1'b1; mem_addr = 16'h4002; mem_wdata = 16'h0000;
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL conflict_stall_t0 got %b required 1", mem_stall);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (!(ram_en === 1'b1 && ram_addr === 15'h2001 && mem_stall === 1'b1 && dmem_r === 1'b0)) begin
                errors++;
                $display("FAIL conflict_dbusy cyc=%0d en=%b addr=%h stall=%b dr=%b required 1 2001 1 0", i, ram_en, ram_addr, mem_stall, dmem_r);
            end
        end
        step();
        checks++;
        if (!(dmem_r === 1'b1 && mem_rdata === 16'hBEEF && mem_stall === 1'b0 && imem_r === 1'b0)) begin
            errors++;
            $display("FAIL conflict_dready dr=%b rd=%h stall=%b ir=%b required 1 beef 0 0", dmem_r, mem_rdata, mem_stall, imem_r);
        end
        mem_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) if_req = 1'b0;
            checks++;
            if (!(ram_en === 1'b1 && ram_addr === 15'h1800 && imem_r === 1'b0)) begin
                errors++;
                $display("FAIL conflict_ibusy cyc=%0d en=%b addr=%h ir=%b required 1 1800 0", i, ram_en, ram_addr, imem_r);
            end
        end
        step();
        checks++;
        if (!(imem_r === 1'b1 && instr === 16'h1234)) begin
            errors++;
            $display("FAIL conflict_iready ir=%b instr=%h required 1 1234", imem_r, instr);
        end
`ifdef LC3BP_MEM_ARB_PERF_EN
        checks++;
        if (!(perf_dgrant === 16'd1 && perf_igrant === 16'd1 && perf_conflict === 16'd5)) begin
            errors++;
            $display("FAIL perf_counts d=%0d i=%0d c=%0d required 1 1 5", perf_dgrant, perf_igrant, perf_conflict);
        end
`endif
        step();
    endtask

    task automatic test_byte();
        mem_req = 1'b1; mem_we = 1'b1; mem_word = 1'b0; mem_addr = 16'h4003; mem_wdata = 16'h00AB;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (!(ram_en === 1'b1 && ram_we === 2'b10 && ram_wdata === 16'hABAB && ram_addr === 15'h2001)) begin
                errors++;
                $display("FAIL byte_store cyc=%0d en=%b we=%b wd=%h addr=%h required 1 10 abab 2001", i, ram_en, ram_we, ram_wdata, ram_addr);
            end
        end
        step();
        checks++;
        if (!(dmem_r === 1'b1 && ram_we === 2'b00)) begin
            errors++;
            $display("FAIL byte_store_done dr=%b we=%b required 1 00", dmem_r, ram_we);
        end
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        run_d(1'b0, 1'b0, 16'h4003, 16'h0000);
        checks++;
        if (mem_rdata !== 16'h00AB) begin
            errors++;
            $display("FAIL byte_load_hi got %h required 00ab", mem_rdata);
        end
        step();
        run_d(1'b0, 1'b0, 16'h4002, 16'h0000);
        checks++;
        if (mem_rdata !== 16'h00EF) begin
            errors++;
            $display("FAIL byte_load_lo got %h required 00ef", mem_rdata);
        end
        step();
        run_d(1'b0, 1'b1, 16'h4003, 16'h0000);
        checks++;
        if (mem_rdata !== 16'hABEF) begin
            errors++;
            $display("FAIL word_load_odd got %h required abef", mem_rdata);
        end
        step();
        run_d(1'b1, 1'b1, 16'h4004, 16'h5A5A);
        step();
        run_d(1'b0, 1'b1, 16'h4004, 16'h0000);
        checks++;
        if (mem_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL word_store_load got %h required 5a5a", mem_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int last;
        int pulses;
        last = -1;
        pulses = 0;
        if_req = 1'b1; if_addr = 16'h3000;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (imem_r) begin
                pulses++;
                checks++;
                if (ram_en !== 1'b0 || instr !== 16'h1234) begin
                    errors++;
                    $display("FAIL b2b_pulse cyc=%0d en=%b instr=%h required 0 1234", cyc, ram_en, instr);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 7) begin
                        errors++;
                        $display("FAIL b2b_interval got %0d required 7", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        if_req = 1'b0;
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d required 4", pulses);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_reset_mid();
        int n;
        mem_req = 1'b1; mem_we = 1'b0; mem_word = 1'b1; mem_addr = 16'h4002;
        step();
        step();
        step();
        rst = 1'b1;
        mem_req = 1'b0;
        step();
        checks++;
        if (!(ram_en === 1'b0 && dmem_r === 1'b0 && mem_rdata === 16'h0000 && instr === 16'h0000 && ram_addr === 15'h0000)) begin
            errors++;
            $display("FAIL rst_mid en=%b dr=%b rd=%h instr=%h addr=%h required 0 0 0000 0000 0000", ram_en, dmem_r, mem_rdata, instr, ram_addr);
        end
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (dmem_r || ram_en) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL rst_no_ready got %0d active cycles required 0", n);
        end
        if_req = 1'b1; if_addr = 16'h3001;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) if_req = 1'b0;
        end while (!imem_r && n < 20);
        checks++;
        if (!(n == 6 && instr === 16'h1234)) begin
            errors++;
            $display("FAIL rst_after_fetch latency=%0d instr=%h required 6 1234", n, instr);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_word = 1'b0; mem_addr = '0; mem_wdata = '0;
        step();
        preload(15'h1800, 16'h1234);
        preload(15'h2001, 16'hBEEF);
        test_reset();
        test_fetch();
        test_conflict();
        test_byte();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
